// File: rtl/shift_iter_pkg.sv
// Shared definitions for the iterative shifter.
//   shift_op_e : operation encoding presented on the op port
//   state_e    : control FSM encoding (IDLE / SHIFT / DONE)
//   DATA_W     : operand width
//   CNT_W      : shift-amount width
package shift_iter_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,  // rotate left
    OP_SLL = 2'b01,  // shift left logical
    OP_SRA = 2'b10,  // shift right arithmetic
    OP_SRL = 2'b11   // shift right logical
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_iter_step.sv
// One combinational shift step of the iterative shifter.
//   in  [15:0] : value before this step
//   op  [1:0]  : operation (shift_op_e encoding)
//   two        : 1 = shift by 2, 0 = shift by 1
//   out [15:0] : value after this step
module shift_step
  import shift_iter_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        op,
  input  logic              two,
  output logic [DATA_W-1:0] out
);

  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    out = in;
    case (shift_op_e'(op))
      OP_ROL: out = two ? {in[13:0], in[15:14]}      : {in[14:0], in[15]};
      OP_SLL: out = two ? {in[13:0], 2'b00}          : {in[14:0], 1'b0};
      OP_SRA: out = two ? {{2{in[15]}}, in[15:2]}    : {in[15], in[15:1]};
      OP_SRL: out = two ? {2'b00, in[15:2]}          : {1'b0, in[15:1]};
      default: out = in;
    endcase
  end

endmodule

// File: rtl/shift_iter.sv
// Multi-cycle 16-bit shifter: 2 bits per cycle, 1 on a final odd step.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : request, accepted only while idle
//   in  [15:0] : operand, captured on accept
//   op  [1:0]  : 00 ROL, 01 SLL, 10 SRA, 11 SRL
//   cnt [3:0]  : shift amount, captured on accept
//   out [15:0] : shift register; final result when done=1, held until next accept
//   busy       : operation in progress
//   done       : one-cycle completion pulse
module shift_iter
  import shift_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in,
  input  logic [1:0]        op,
  input  logic [CNT_W-1:0]  cnt,
  output logic [DATA_W-1:0] out,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  shift_op_e           op_q, op_d;
  logic [DATA_W-1:0]   sh_q, sh_d;

  logic                take_two;
  logic [DATA_W-1:0]   step_out;

  assign take_two = (rem_q >= CNT_W'(2));

  shift_step u_step (
    .in  (sh_q),
    .op  (op_q),
    .two (take_two),
    .out (step_out)
  );

  // State register: FSM state plus the datapath registers it controls.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      op_q    <= OP_ROL;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sh_d    = sh_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sh_d    = in;
          rem_d   = cnt;
          op_d    = shift_op_e'(op);
          state_d = (cnt != '0) ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        sh_d  = step_out;
        rem_d = take_two ? (rem_q - CNT_W'(2)) : '0;
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: out is the shift register itself, qualified externally by done.
  always_comb begin
    out  = sh_q;
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

endmodule
